// File: rtl/bldc_pkg.sv
// ============================================================================
//  Module      : bldc_pkg
//  Description : Shared types and helpers for the BLDC start-up sequencer:
//                sequencer state encodings, bldc mode codes and a signed
//                velocity clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bldc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [7:0] MODE_CLOSED   = 8'd0;
    localparam logic [7:0] MODE_POSITION = 8'd1;

    // Saturate a widened signed velocity to [-lim, +lim] and narrow to 16 bits.
    function automatic logic signed [15:0] vel_clamp(input logic signed [17:0] v,
                                                     input logic signed [17:0] lim);
        logic signed [17:0] w_res;
        w_res = v;
        if (v > lim)
            w_res = lim;
        else if (v < -lim)
            w_res = -lim;
        return w_res[15:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/bldc_startup_seq_if.sv
// ============================================================================
//  Module      : bldc_startup_seq_if
//  Description : Host-register and bldc-datapath signal bundle of the start-up
//                sequencer. master = host/datapath side, slave = sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bldc_startup_seq_if;
    logic               run_req;
    logic signed [15:0] target_vel;
    logic signed [15:0] cal_offset;
    logic        [15:0] feedback;
    logic               fault_clr;
    logic               bldc_enable;
    logic        [7:0]  bldc_mode;
    logic signed [15:0] bldc_velocity;
    logic signed [15:0] bldc_offset;
    logic        [2:0]  state;
    logic               fault;

    modport master (
        output run_req, target_vel, cal_offset, feedback, fault_clr,
        input  bldc_enable, bldc_mode, bldc_velocity, bldc_offset, state, fault
    );

    modport slave (
        input  run_req, target_vel, cal_offset, feedback, fault_clr,
        output bldc_enable, bldc_mode, bldc_velocity, bldc_offset, state, fault
    );
endinterface

`default_nettype wire

// File: rtl/bldc_vel_slew.sv
// ============================================================================
//  Module      : bldc_vel_slew
//  Description : Velocity register with direct load and tick-driven signed
//                slew toward a target, VEL_STEP per tick, no overshoot,
//                saturated to +/-VEL_MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bldc_vel_slew
    import bldc_pkg::*;
#(
    parameter int VEL_STEP = 1,
    parameter int VEL_MAX  = 255
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               tick,
    input  wire logic               load,
    input  wire logic signed [15:0] load_val,
    input  wire logic               slew_en,
    input  wire logic signed [15:0] target,
    output logic signed [15:0]      vel
);

    localparam logic signed [17:0] c_LIM  = 18'(VEL_MAX);
    localparam logic signed [17:0] c_STEP = 18'(VEL_STEP);

    logic signed [15:0] r_vel;
    logic signed [15:0] w_vel_next;
    logic signed [15:0] w_tgt;
    logic signed [17:0] w_cur_x;
    logic signed [17:0] w_tgt_x;
    logic signed [17:0] w_load_x;

    assign w_cur_x  = $signed({{2{r_vel[15]}}, r_vel});
    assign w_load_x = $signed({{2{load_val[15]}}, load_val});
    assign w_tgt    = vel_clamp($signed({{2{target[15]}}, target}), c_LIM);
    assign w_tgt_x  = $signed({{2{w_tgt[15]}}, w_tgt});
    assign vel      = r_vel;

    // Next velocity: load has priority, otherwise one bounded step per tick.
    always_comb begin
        w_vel_next = r_vel;
        if (load) begin
            w_vel_next = vel_clamp(w_load_x, c_LIM);
        end else if (slew_en && tick) begin
            if (w_tgt_x > w_cur_x) begin
                if ((w_tgt_x - w_cur_x) > c_STEP)
                    w_vel_next = vel_clamp(w_cur_x + c_STEP, c_LIM);
                else
                    w_vel_next = w_tgt;
            end else if (w_tgt_x < w_cur_x) begin
                if ((w_cur_x - w_tgt_x) > c_STEP)
                    w_vel_next = vel_clamp(w_cur_x - c_STEP, c_LIM);
                else
                    w_vel_next = w_tgt;
            end
        end
    end

    // Velocity register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_vel <= '0;
        else
            r_vel <= w_vel_next;
    end

endmodule

`default_nettype wire

// File: rtl/bldc_startup_seq.sv
// ============================================================================
//  Module      : bldc_startup_seq
//  Description : BLDC start/stop sequencer: rotor alignment, open-loop angle
//                ramp, hand-over to closed loop, slewed stop.
//                Optional stall detection enabled by defining STALL_DETECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bldc_startup_seq
    import bldc_pkg::*;
#(
    parameter int TICK_DIV       = 1000,
    parameter int ALIGN_TICKS    = 500,
    parameter int ALIGN_VEL      = 64,
    parameter int RAMP_PER_START = 40,
    parameter int RAMP_PER_END   = 4,
    parameter int VEL_STEP       = 1,
    parameter int VEL_MAX        = 255,
    parameter int STALL_TICKS    = 2000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    bldc_startup_seq_if.slave bus
);

    localparam logic [15:0] c_TICK_LAST     = 16'(TICK_DIV - 1);
    localparam logic [15:0] c_ALIGN_TICKS   = 16'(ALIGN_TICKS);
    localparam logic [15:0] c_RAMP_START    = 16'(RAMP_PER_START);
    localparam logic [15:0] c_RAMP_END      = 16'(RAMP_PER_END);
    localparam logic [15:0] c_ALIGN_VEL     = 16'(ALIGN_VEL);
    localparam logic [15:0] c_ALIGN_VEL_NEG = 16'(-ALIGN_VEL);

    state_t      r_state,  w_state_next;
    logic [15:0] r_div;
    logic [15:0] r_cnt,    w_cnt_next;
    logic [15:0] r_period, w_period_next;
    logic        r_dir_neg, w_dir_neg_next;
    logic        r_enable, w_enable_next;
    logic [7:0]  r_mode,   w_mode_next;
    logic [15:0] r_offset, w_offset_next;

    logic        w_tick;
    logic        w_load;
    logic [15:0] w_load_val;
    logic        w_slew_en;
    logic [15:0] w_slew_tgt;
    logic [15:0] w_vel;
    logic [15:0] w_dir_step;
    logic [15:0] w_dir_vel;
    logic        w_stall_hit;

    assign w_tick     = (r_div == c_TICK_LAST);
    assign w_dir_step = r_dir_neg ? 16'hFFFF : 16'h0001;
    assign w_dir_vel  = r_dir_neg ? c_ALIGN_VEL_NEG : c_ALIGN_VEL;

    // Free-running tick divider, independent of sequencer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else
            r_div <= r_div + 16'd1;
    end

    // Sequencer and registered-output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_dir_neg <= 1'b0;
            r_enable  <= 1'b0;
            r_mode    <= '0;
            r_offset  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_period  <= w_period_next;
            r_dir_neg <= w_dir_neg_next;
            r_enable  <= w_enable_next;
            r_mode    <= w_mode_next;
            r_offset  <= w_offset_next;
        end
    end

    // Next state and next output values; outputs follow state one clk later.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_period_next  = r_period;
        w_dir_neg_next = r_dir_neg;
        w_enable_next  = 1'b0;
        w_mode_next    = MODE_CLOSED;
        w_offset_next  = '0;
        w_load         = 1'b1;
        w_load_val     = '0;
        w_slew_en      = 1'b0;
        w_slew_tgt     = '0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (bus.run_req && (bus.target_vel != 16'sd0)) begin
                    w_state_next   = ST_ALIGN;
                    w_dir_neg_next = bus.target_vel[15];
                end
            end

            ST_ALIGN: begin
                w_enable_next = 1'b1;
                w_mode_next   = MODE_POSITION;
                w_load_val    = c_ALIGN_VEL;
                if (!bus.run_req) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (w_tick) begin
                    if (r_cnt + 16'd1 == c_ALIGN_TICKS) begin
                        w_state_next  = ST_RAMP;
                        w_cnt_next    = '0;
                        w_period_next = c_RAMP_START;
                    end else begin
                        w_cnt_next = r_cnt + 16'd1;
                    end
                end
            end

            ST_RAMP: begin
                w_enable_next = 1'b1;
                w_mode_next   = MODE_POSITION;
                w_offset_next = r_offset;
                w_load_val    = c_ALIGN_VEL;
                if (!bus.run_req) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (w_tick) begin
                    if (r_cnt + 16'd1 == r_period) begin
                        // Angle step; the step that shortens the period to
                        // its final value hands over to closed loop.
                        w_offset_next = r_offset + w_dir_step;
                        w_period_next = r_period - 16'd1;
                        w_cnt_next    = '0;
                        if (r_period - 16'd1 == c_RAMP_END) begin
                            w_state_next = ST_RUN;
                            w_load_val   = w_dir_vel;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 16'd1;
                    end
                end
            end

            ST_RUN: begin
                w_enable_next = 1'b1;
                w_offset_next = bus.cal_offset;
                w_load        = 1'b0;
                w_slew_en     = 1'b1;
                w_slew_tgt    = bus.target_vel;
                if (!bus.run_req)
                    w_state_next = ST_STOP;
                else if (w_stall_hit)
                    w_state_next = ST_FAULT;
            end

            ST_STOP: begin
                w_enable_next = 1'b1;
                w_offset_next = bus.cal_offset;
                w_load        = 1'b0;
                w_slew_en     = 1'b1;
                if (bus.run_req)
                    w_state_next = ST_RUN;
                else if (w_vel == 16'd0)
                    w_state_next = ST_IDLE;
            end

            ST_FAULT: begin
                if (bus.fault_clr && !bus.run_req)
                    w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    bldc_vel_slew #(
        .VEL_STEP (VEL_STEP),
        .VEL_MAX  (VEL_MAX)
    ) u_vel_slew (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (w_tick),
        .load     (w_load),
        .load_val (w_load_val),
        .slew_en  (w_slew_en),
        .target   (w_slew_tgt),
        .vel      (w_vel)
    );

`ifdef STALL_DETECT_EN
    localparam logic [15:0] c_STALL_LAST = 16'(STALL_TICKS - 1);

    logic [15:0] r_fb_prev;
    logic [15:0] r_stall_cnt;
    logic        r_fault;
    logic [15:0] w_vel_abs;
    logic        w_stall_arm;
    logic        w_fb_same;

    assign w_vel_abs   = w_vel[15] ? (16'd0 - w_vel) : w_vel;
    assign w_stall_arm = (r_state == ST_RUN) && (w_vel_abs >= c_ALIGN_VEL);
    assign w_fb_same   = (bus.feedback == r_fb_prev);
    assign w_stall_hit = w_stall_arm && w_fb_same && w_tick && (r_stall_cnt == c_STALL_LAST);

    // Count ticks of unchanged feedback while running at speed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_prev   <= '0;
            r_stall_cnt <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_fb_prev <= bus.feedback;
            r_fault   <= (r_state == ST_FAULT);
            if (!w_stall_arm || !w_fb_same)
                r_stall_cnt <= '0;
            else if (w_tick)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.fault = r_fault;
`else
    assign w_stall_hit = 1'b0;
    assign bus.fault   = 1'b0;
`endif

    assign bus.state         = r_state;
    assign bus.bldc_enable   = r_enable;
    assign bus.bldc_mode     = r_mode;
    assign bus.bldc_velocity = w_vel;
    assign bus.bldc_offset   = r_offset;

endmodule

`default_nettype wire

// File: tb/tb_bldc_startup_seq.sv
// ============================================================================
//  Module      : tb_bldc_startup_seq
//  Description : Directed self-checking bench for bldc_startup_seq with
//                TICK_DIV = 4. Stall section active when STALL_DETECT_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bldc_startup_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bldc_startup_seq_if bif ();

    bldc_startup_seq #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int max_abs;
    int max_jump;
    int saw_zero;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget, output int cyc);
        cyc = 0;
        while (bif.state !== s && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        assert (bif.state === s) else begin
            n_fail++;
            $error("FAIL %s timeout observed_state=%0d expected_state=%0d", tag, bif.state, s);
        end
    endtask

    // Waits for a velocity value while tracking peak magnitude, largest
    // per-clk change and whether zero was crossed.
    task automatic wait_vel(input string tag, input int v, input int budget, output int cyc);
        int cur;
        int prv;
        cyc = 0;
        prv = int'(bif.bldc_velocity);
        while (int'(bif.bldc_velocity) != v && cyc < budget) begin
            @(negedge clk);
            cyc++;
            cur = int'(bif.bldc_velocity);
            if ((cur < 0 ? -cur : cur) > max_abs) max_abs = (cur < 0 ? -cur : cur);
            if ((cur - prv < 0 ? prv - cur : cur - prv) > max_jump)
                max_jump = (cur - prv < 0 ? prv - cur : cur - prv);
            if (cur == 0) saw_zero = 1;
            prv = cur;
        end
        n_tests++;
        assert (int'(bif.bldc_velocity) == v) else begin
            n_fail++;
            $error("FAIL %s timeout observed_vel=%0d expected_vel=%0d", tag, bif.bldc_velocity, v);
        end
    endtask

    initial begin
        int c;
        int bad;
        logic [15:0] prev_off;

        bif.run_req    = 1'b0;
        bif.target_vel = '0;
        bif.cal_offset = '0;
        bif.feedback   = 16'h0055;
        bif.fault_clr  = 1'b0;
        max_abs = 0; max_jump = 0; saw_zero = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state",  16'(bif.state), 16'd0);
        check("rst_enable", 16'(bif.bldc_enable), 16'd0);
        check("rst_mode",   16'(bif.bldc_mode), 16'd0);
        check("rst_vel",    bif.bldc_velocity, 16'd0);
        check("rst_offset", bif.bldc_offset, 16'd0);
        check("rst_fault",  16'(bif.fault), 16'd0);
        rst_n = 1'b1;

        // Zero target must not start the motor
        bif.run_req = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_tgt0", 16'(bif.state), 16'd0);
        bif.run_req = 1'b0;
        @(negedge clk);

        // Full start towards +200
        bif.target_vel = 16'sd200;
        bif.cal_offset = 16'h1234;
        bif.run_req    = 1'b1;
        @(negedge clk);
        check("align_entry", 16'(bif.state), 16'd1);
        @(negedge clk);
        check("align_enable", 16'(bif.bldc_enable), 16'd1);
        check("align_mode",   16'(bif.bldc_mode), 16'd1);
        check("align_vel",    bif.bldc_velocity, 16'd64);
        check("align_offset", bif.bldc_offset, 16'd0);
        wait_state("to_ramp", 3'd2, 2100, c);
        check_rng("align_len", c + 1, 1997, 2000);

        // RAMP: offset climbs by exactly one per step until hand-over
        c = 0; bad = 0; prev_off = 16'd0;
        while (bif.state !== 3'd3 && c < 3300) begin
            @(negedge clk);
            c++;
            if (bif.bldc_offset != prev_off) begin
                if (bif.bldc_offset != prev_off + 16'd1) bad++;
                prev_off = bif.bldc_offset;
            end
        end
        check("ramp_len", 16'(c), 16'd3240);
        check("ramp_unit_steps", 16'(bad), 16'd0);
        check("ramp_last_offset", bif.bldc_offset, 16'd36);
        check("run_entry_vel", bif.bldc_velocity, 16'd64);
        @(negedge clk);
        check("run_mode",   16'(bif.bldc_mode), 16'd0);
        check("run_offset", bif.bldc_offset, 16'h1234);
        check("run_fault",  16'(bif.fault), 16'd0);
        wait_vel("slew_to_200", 200, 700, c);
        check("slew_200_len", 16'(c + 1), 16'd544);
        repeat (20) @(negedge clk);
        check("hold_200", bif.bldc_velocity, 16'd200);

        // Slew through zero to a negative target
        bif.target_vel = 16'sd100;
        wait_vel("slew_to_100", 100, 500, c);
        check_rng("slew_100_len", c, 397, 400);
        bif.target_vel = -16'sd100;
        max_abs = 0; max_jump = 0; saw_zero = 0;
        wait_vel("slew_to_m100", -100, 900, c);
        check_rng("slew_m100_len", c, 797, 800);
        check("slew_m100_jump", 16'(max_jump), 16'd1);
        check("slew_m100_zero", 16'(saw_zero), 16'd1);

        // Saturation at +VEL_MAX
        bif.target_vel = 16'sh7FFF;
        max_abs = 0;
        wait_vel("slew_to_max", 255, 1500, c);
        check_rng("slew_max_len", c, 1417, 1420);
        repeat (20) @(negedge clk);
        check("sat_vel", bif.bldc_velocity, 16'd255);
        check("sat_peak", 16'(max_abs), 16'd255);
        bif.target_vel = 16'sd80;
        wait_vel("slew_to_80", 80, 800, c);

        // Stop from +80
        bif.run_req = 1'b0;
        @(negedge clk);
        check("stop_entry", 16'(bif.state), 16'd4);
        wait_vel("stop_to_0", 0, 400, c);
        check_rng("stop_len", c + 1, 317, 320);
        wait_state("stop_to_idle", 3'd0, 5, c);
        @(negedge clk);
        check("idle_enable", 16'(bif.bldc_enable), 16'd0);
        check("idle_vel", bif.bldc_velocity, 16'd0);

        // Negative direction ramp with 16-bit wrap, then reset mid-RAMP
        bif.target_vel = -16'sd50;
        bif.cal_offset = 16'h0042;
        bif.run_req    = 1'b1;
        wait_state("neg_to_ramp", 3'd2, 2110, c);
        c = 0;
        while (bif.bldc_offset == 16'd0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("neg_step1", bif.bldc_offset, 16'hFFFF);
        c = 0;
        while (bif.bldc_offset == 16'hFFFF && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("neg_step2", bif.bldc_offset, 16'hFFFE);
        check("neg_in_ramp", 16'(bif.state), 16'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state",  16'(bif.state), 16'd0);
        check("mid_rst_enable", 16'(bif.bldc_enable), 16'd0);
        check("mid_rst_mode",   16'(bif.bldc_mode), 16'd0);
        check("mid_rst_vel",    bif.bldc_velocity, 16'd0);
        check("mid_rst_offset", bif.bldc_offset, 16'd0);
        bif.run_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef STALL_DETECT_EN
        // Frozen feedback in RUN trips FAULT after STALL_TICKS ticks
        bif.target_vel = 16'sd100;
        bif.run_req    = 1'b1;
        wait_state("stall_to_run", 3'd3, 6000, c);
        wait_state("stall_to_fault", 3'd5, 9000, c);
        check_rng("stall_len", c, 7996, 8004);
        @(negedge clk);
        check("fault_flag", 16'(bif.fault), 16'd1);
        check("fault_enable", 16'(bif.bldc_enable), 16'd0);
        check("fault_vel", bif.bldc_velocity, 16'd0);
        bif.fault_clr = 1'b1;
        @(negedge clk);
        bif.fault_clr = 1'b0;
        @(negedge clk);
        check("fault_clr_ignored", 16'(bif.state), 16'd5);
        bif.run_req   = 1'b0;
        bif.fault_clr = 1'b1;
        @(negedge clk);
        bif.fault_clr = 1'b0;
        check("fault_clr_idle", 16'(bif.state), 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
